// File: rtl/bit_count_pkg.sv
// bit_count_pkg: shared types and helpers for the bit_count_engine slice.
//   state_e  - engine FSM states (IDLE, COUNT, DONE)
//   clog2    - ceiling log2, usable in constant expressions
//   sat_add  - unsigned add that clamps at a caller-supplied limit
package bit_count_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Smallest r with 2**r >= v (clog2(1) = 0).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // a + b, clamped to lim; the 33-bit sum never wraps before the compare.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction

endpackage

// File: rtl/bit_count_engine_chunk_popcount.sv
// chunk_popcount: combinational population count of one CHUNK_W-bit chunk.
//   chunk  in   CHUNK_W        bits to count
//   cnt    out  clog2(CHUNK_W+1) number of ones in chunk
module chunk_popcount
    import bit_count_pkg::*;
#(
    parameter int CHUNK_W = 8,
    localparam int CW = clog2(CHUNK_W + 1)
) (
    input  logic [CHUNK_W-1:0] chunk,
    output logic [CW-1:0]      cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            cnt = cnt + CW'(chunk[i]);
        end
    end

endmodule

// File: rtl/bit_count_engine.sv
// bit_count_engine: multi-cycle population counter with a saturating frame total.
// Words arrive on a valid/ready handshake, are counted CHUNK_W bits per clock
// (ones, or zeros when in_mode=1) and the result is held until consumed.
// Optional feature macro: BITCNT_PARITY_EN adds out_parity (XOR of raw in_data).
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid/in_ready        input handshake; in_ready is combinational
//   in_data, in_mode, in_last word, count-zeros select, end-of-frame flag
//   out_valid/out_ready      result handshake
//   out_count                per-word count
//   out_total                saturating frame total including this word
//   out_last                 result closes the frame
//   out_parity               (BITCNT_PARITY_EN only) XOR of all in_data bits
module bit_count_engine
    import bit_count_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8,
    parameter int TOT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_mode,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [clog2(DATA_W+1)-1:0]   out_count,
    output logic [TOT_W-1:0]             out_total,
    output logic                         out_last
`ifdef BITCNT_PARITY_EN
   ,output logic                         out_parity
`endif
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W  = clog2(DATA_W + 1);
    localparam int CW     = clog2(CHUNK_W + 1);
    localparam int IDX_W  = clog2(NCHUNK + 1);
    localparam logic [31:0] TOT_MAX = (TOT_W >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << TOT_W) - 32'd1);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               mode_q, mode_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   part_q, part_d;
    logic [TOT_W-1:0]   acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic [TOT_W-1:0]   out_total_q, out_total_d;
    logic               out_last_q, out_last_d;

    logic [CW-1:0]      chunk_cnt;
    logic [CW-1:0]      chunk_adj;
    logic [CNT_W-1:0]   word_cnt;
    logic               last_chunk;
    logic               accept;
    logic               result_load;

    chunk_popcount #(.CHUNK_W(CHUNK_W)) u_chunk (
        .chunk (shreg_q[CHUNK_W-1:0]),
        .cnt   (chunk_cnt)
    );

    // Accepting in DONE overlaps consuming the old result with taking a new word.
    assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept      = in_valid && in_ready;
    assign last_chunk  = (idx_q == IDX_W'(NCHUNK - 1));
    assign result_load = (state_q == COUNT) && last_chunk;

    always_comb begin
        chunk_adj = mode_q ? (CW'(CHUNK_W) - chunk_cnt) : chunk_cnt;
        word_cnt  = part_q + CNT_W'(chunk_adj);

        state_d     = state_q;
        shreg_d     = shreg_q;
        mode_d      = mode_q;
        last_d      = last_q;
        idx_d       = idx_q;
        part_d      = part_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_total_d = out_total_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: ;
            COUNT: begin
                shreg_d = shreg_q >> CHUNK_W;
                part_d  = word_cnt;
                idx_d   = idx_q + 1'b1;
                if (last_chunk) begin
                    out_count_d = word_cnt;
                    out_total_d = TOT_W'(sat_add(32'(acc_q), 32'(word_cnt), TOT_MAX));
                    acc_d       = out_total_d;
                    out_last_d  = last_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) acc_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Word capture is shared by IDLE and DONE; overrides the state defaults.
        if (accept) begin
            shreg_d = in_data;
            mode_d  = in_mode;
            last_d  = in_last;
            idx_d   = '0;
            part_d  = '0;
            state_d = COUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            mode_q      <= 1'b0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            part_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_total_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            mode_q      <= mode_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            part_q      <= part_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_total_q <= out_total_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_total = out_total_q;
    assign out_last  = out_last_q;

`ifdef BITCNT_PARITY_EN
    // Parity is taken from the raw word at accept, so in_mode never affects it.
    logic par_lat_q, par_lat_d;
    logic out_parity_q, out_parity_d;

    always_comb begin
        par_lat_d    = accept ? ^in_data : par_lat_q;
        out_parity_d = result_load ? par_lat_q : out_parity_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_lat_q    <= 1'b0;
            out_parity_q <= 1'b0;
        end else begin
            par_lat_q    <= par_lat_d;
            out_parity_q <= out_parity_d;
        end
    end

    assign out_parity = out_parity_q;
`endif

endmodule
